// File: rtl/regfile_layer_cfg_if.sv
// Host register bus for the layer-configuration bank: single-cycle strobes,
// registered read data with a valid flag and an access-error pulse.
interface regfile_layer_cfg_if #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 16
);
  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              rd_valid;
  logic              acc_err;

  modport master (
    output wr_en, rd_en, addr, write_data,
    input  read_data, rd_valid, acc_err
  );

  modport slave (
    input  wr_en, rd_en, addr, write_data,
    output read_data, rd_valid, acc_err
  );
endinterface

// File: rtl/regfile_layer_cfg.sv
// Layer-configuration register bank: CTRL/STATUS word at index 0, double-buffered
// RW config (shadow written by host, active loaded on START), RO status pass-through.
module regfile_layer_cfg #(
  parameter int unsigned               DATA_W    = 16,
  parameter int unsigned               ADDR_W    = 14,
  parameter logic [ADDR_W-1:0]         BASE_ADDR = ADDR_W'('h100),
  parameter int unsigned               N_REGS    = 24,
  parameter logic [N_REGS-1:0]         RO_MASK   = '0,
  parameter logic [N_REGS*DATA_W-1:0]  RST_VAL   = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  regfile_layer_cfg_if.slave         bus,
  output logic [N_REGS*DATA_W-1:0]   cfg_active,
  input  logic [N_REGS*DATA_W-1:0]   hw_status,
  output logic                       start_pulse,
  input  logic                       eng_busy,
  input  logic                       eng_done,
  output logic                       irq
);

  localparam int unsigned IDX_W  = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam int unsigned OFF_W  = ADDR_W + 1;
  localparam int unsigned BANK_W = N_REGS * DATA_W;
  localparam logic [N_REGS-1:0] RW_MASK = ~(RO_MASK | N_REGS'(1));

  // Bit mask covering only the RW slices, so CTRL/RO slices stay 0 in both copies.
  function automatic logic [BANK_W-1:0] rw_bits_f();
    logic [BANK_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < N_REGS; i++) begin
      if (RW_MASK[i]) m[i*DATA_W +: DATA_W] = '1;
    end
    return m;
  endfunction

  localparam logic [BANK_W-1:0] RW_BITS = rw_bits_f();
  localparam logic [BANK_W-1:0] RST_RW  = RST_VAL & RW_BITS;

  logic [BANK_W-1:0] shadow_q, shadow_d;
  logic [BANK_W-1:0] active_q, active_d;
  logic              done_q, done_d;
  logic              irq_en_q, irq_en_d;
  logic              err_q, err_d;
  logic              eng_done_q;
  logic              irq_q, irq_d;
  logic              start_q, start_d;
  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              acc_err_q, acc_err_d;

  logic [OFF_W-1:0]  off_c;
  logic              hit_c;
  logic [IDX_W-1:0]  idx_c;
  logic              sel_ro_c;
  logic              sel_ctrl_c;
  logic [DATA_W-1:0] rd_word_c;
  logic [DATA_W-1:0] ctrl_word_c;
  logic              wr_hit_c;
  logic              wr_ctrl_c;
  logic              start_req_c;
  logic              start_ok_c;

  // Address decode: offset computed one bit wider so the upper bound never wraps.
  assign off_c      = {1'b0, bus.addr} - {1'b0, BASE_ADDR};
  assign hit_c      = (bus.addr >= BASE_ADDR) && (off_c < OFF_W'(N_REGS));
  assign idx_c      = off_c[IDX_W-1:0];
  assign sel_ctrl_c = (idx_c == '0);

  assign ctrl_word_c = DATA_W'({err_q, eng_busy, irq_en_q, done_q, 1'b0});

  always_comb begin
    sel_ro_c  = 1'b0;
    rd_word_c = '0;
    for (int unsigned i = 1; i < N_REGS; i++) begin
      if (idx_c == IDX_W'(i)) begin
        sel_ro_c  = RO_MASK[i];
        rd_word_c = RO_MASK[i] ? hw_status[i*DATA_W +: DATA_W]
                               : shadow_q[i*DATA_W +: DATA_W];
      end
    end
    if (sel_ctrl_c) rd_word_c = ctrl_word_c;
  end

  assign wr_hit_c    = bus.wr_en && hit_c;
  assign wr_ctrl_c   = wr_hit_c && sel_ctrl_c;
  assign start_req_c = wr_ctrl_c && bus.write_data[0];
  assign start_ok_c  = start_req_c && !eng_busy;

  // Next-state for registers, bank copies and status bits.
  always_comb begin
    shadow_d    = shadow_q;
    active_d    = active_q;
    read_data_d = read_data_q;
    rd_valid_d  = bus.rd_en;
    start_d     = start_ok_c;

    for (int unsigned i = 0; i < N_REGS; i++) begin
      if (RW_MASK[i] && wr_hit_c && (idx_c == IDX_W'(i))) begin
        shadow_d[i*DATA_W +: DATA_W] = bus.write_data;
      end
    end
    if (start_ok_c) begin
      active_d = shadow_q & RW_BITS;
    end

    if (bus.rd_en) begin
      read_data_d = hit_c ? rd_word_c : '0;
    end

    // Misses on both strobes in one cycle collapse into a single pulse.
    acc_err_d = (!hit_c && (bus.wr_en || bus.rd_en))
              || (wr_hit_c && !sel_ctrl_c && sel_ro_c)
              || (start_req_c && eng_busy);

    irq_en_d = wr_ctrl_c ? bus.write_data[2] : irq_en_q;
    done_d   = (eng_done && !eng_done_q)
             || (done_q && !(wr_ctrl_c && bus.write_data[1]));
    err_d    = acc_err_d
             || (err_q && !(wr_ctrl_c && bus.write_data[4]));
    irq_d    = done_d && irq_en_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q    <= RST_RW;
      active_q    <= RST_RW;
      done_q      <= 1'b0;
      irq_en_q    <= 1'b0;
      err_q       <= 1'b0;
      eng_done_q  <= 1'b0;
      irq_q       <= 1'b0;
      start_q     <= 1'b0;
      read_data_q <= '0;
      rd_valid_q  <= 1'b0;
      acc_err_q   <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      done_q      <= done_d;
      irq_en_q    <= irq_en_d;
      err_q       <= err_d;
      eng_done_q  <= eng_done;
      irq_q       <= irq_d;
      start_q     <= start_d;
      read_data_q <= read_data_d;
      rd_valid_q  <= rd_valid_d;
      acc_err_q   <= acc_err_d;
    end
  end

  assign bus.read_data = read_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.acc_err   = acc_err_q;
  assign cfg_active    = active_q;
  assign start_pulse   = start_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_regfile_layer_cfg.sv
// Directed bench for regfile_layer_cfg: stimulus pushes expected read/error responses,
// a negedge monitor pops and compares whenever the bus presents them.
module tb_regfile_layer_cfg;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 14;
  localparam int unsigned NR = 24;
  localparam logic [NR-1:0] RO_M = 24'h00F000;

  function automatic logic [NR*DW-1:0] mk_rst();
    logic [NR*DW-1:0] v;
    for (int i = 0; i < int'(NR); i++) v[i*DW +: DW] = 16'hA000 + 16'(i);
    return v;
  endfunction

  localparam logic [NR*DW-1:0] RST_V = mk_rst();

  typedef struct packed {
    logic [DW-1:0] data;
    logic          err;
  } rd_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NR*DW-1:0] cfg_active;
  logic [NR*DW-1:0] hw_status;
  logic start_pulse, irq;
  logic eng_busy = 1'b0;
  logic eng_done = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;
  rd_exp_t rd_q[$];
  logic    err_q[$];

  regfile_layer_cfg_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

  regfile_layer_cfg #(
    .DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(14'h100), .N_REGS(NR),
    .RO_MASK(RO_M), .RST_VAL(RST_V)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus_if), .cfg_active(cfg_active),
    .hw_status(hw_status), .start_pulse(start_pulse), .eng_busy(eng_busy),
    .eng_done(eng_done), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
  endtask

  function automatic logic [AW-1:0] A(input int i);
    return AW'(32'h100 + i);
  endfunction

  function automatic logic [DW-1:0] act_sl(input int i);
    return cfg_active[i*DW +: DW];
  endfunction

  // Monitor: compares each presented read (and stray acc_err pulse) against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_if.rd_valid) begin
        chk("rd_expected", 32'(rd_q.size() != 0), 32'd1);
        if (rd_q.size() != 0) begin
          rd_exp_t e;
          e = rd_q.pop_front();
          chk("rd_data", 32'(bus_if.read_data), 32'(e.data));
          chk("rd_acc_err", 32'(bus_if.acc_err), 32'(e.err));
        end
      end else if (bus_if.acc_err) begin
        chk("wr_acc_err_expected", 32'(err_q.size() != 0), 32'd1);
        if (err_q.size() != 0) void'(err_q.pop_front());
      end
    end
  end

  task automatic op(input logic wr, input logic rd, input logic [AW-1:0] a,
                    input logic [DW-1:0] wd, input logic dn,
                    input logic [DW-1:0] exp_rd, input logic exp_err);
    @(negedge clk);
    bus_if.wr_en      = wr;
    bus_if.rd_en      = rd;
    bus_if.addr       = a;
    bus_if.write_data = wd;
    eng_done          = dn;
    if (rd) rd_q.push_back('{data: exp_rd, err: exp_err});
    else if (exp_err) err_q.push_back(1'b1);
    @(negedge clk);
    bus_if.wr_en = 1'b0;
    bus_if.rd_en = 1'b0;
    eng_done     = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic e);
    op(1'b1, 1'b0, a, d, 1'b0, '0, e);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] x, input logic e);
    op(1'b0, 1'b1, a, '0, 1'b0, x, e);
  endtask

  initial begin
    logic [NR*DW-1:0] exp_bank;
    bus_if.wr_en = 1'b0;
    bus_if.rd_en = 1'b0;
    bus_if.addr = '0;
    bus_if.write_data = '0;
    for (int i = 0; i < int'(NR); i++) hw_status[i*DW +: DW] = 16'h5000 + 16'(i);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset contents: CTRL 0, RO = hw_status, RW = reset value; RO/CTRL active slices 0.
    for (int i = 0; i < int'(NR); i++) begin
      chk($sformatf("rst_active_%0d", i), 32'(act_sl(i)),
          (i == 0 || RO_M[i]) ? 32'd0 : 32'(16'hA000 + 16'(i)));
    end
    chk("rst_start_pulse", 32'(start_pulse), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    for (int i = 0; i < int'(NR); i++) begin
      rd(A(i), (i == 0) ? 16'h0000 : (RO_M[i] ? 16'h5000 + 16'(i) : 16'hA000 + 16'(i)), 1'b0);
    end

    // Shadow write is invisible to the engine until START.
    wr(A(1), 16'h0020, 1'b0);
    rd(A(1), 16'h0020, 1'b0);
    chk("active1_before_start", 32'(act_sl(1)), 32'h0000A001);
    wr(A(0), 16'h0001, 1'b0);
    chk("start_pulse_hi", 32'(start_pulse), 32'd1);
    chk("active1_after_start", 32'(act_sl(1)), 32'h00000020);
    @(negedge clk);
    chk("start_pulse_one_cycle", 32'(start_pulse), 32'd0);
    rd(A(0), 16'h0000, 1'b0);

    // Same-cycle write and read of one index returns the old value.
    op(1'b1, 1'b1, A(2), 16'h1234, 1'b0, 16'hA002, 1'b0);
    rd(A(2), 16'h1234, 1'b0);

    // START while busy: ignored, error pulse, ERR and BUSY visible.
    eng_busy = 1'b1;
    wr(A(1), 16'h0040, 1'b0);
    wr(A(0), 16'h0001, 1'b1);
    chk("busy_no_start_pulse", 32'(start_pulse), 32'd0);
    rd(A(0), 16'h0018, 1'b0);
    rd(A(1), 16'h0040, 1'b0);
    chk("busy_active1_kept", 32'(act_sl(1)), 32'h00000020);
    eng_busy = 1'b0;
    wr(A(0), 16'h0010, 1'b0);
    rd(A(0), 16'h0000, 1'b0);

    // DONE / IRQ: rise sets, set beats a coincident W1C, lone W1C clears.
    wr(A(0), 16'h0004, 1'b0);
    op(1'b0, 1'b0, '0, '0, 1'b1, '0, 1'b0);
    chk("irq_after_done", 32'(irq), 32'd1);
    rd(A(0), 16'h0006, 1'b0);
    op(1'b1, 1'b0, A(0), 16'h0006, 1'b1, '0, 1'b0);
    chk("irq_set_wins", 32'(irq), 32'd1);
    rd(A(0), 16'h0006, 1'b0);
    wr(A(0), 16'h0006, 1'b0);
    chk("irq_cleared", 32'(irq), 32'd0);
    rd(A(0), 16'h0004, 1'b0);

    // RO write and out-of-range accesses.
    wr(A(12), 16'hFFFF, 1'b1);
    rd(A(12), 16'h500C, 1'b0);
    chk("ro_active_zero", 32'(act_sl(12)), 32'd0);
    wr(A(24), 16'hBEEF, 1'b1);
    rd(A(24), 16'h0000, 1'b1);
    rd(14'h0FF, 16'h0000, 1'b1);
    op(1'b1, 1'b1, A(30), 16'h1111, 1'b0, 16'h0000, 1'b1);
    rd(A(0), 16'h0014, 1'b0);
    @(negedge clk);
    chk("read_data_holds", 32'(bus_if.read_data), 32'h00000014);
    chk("rd_valid_low", 32'(bus_if.rd_valid), 32'd0);

    // Mid-run reset right after a START with IRQ pending.
    wr(A(0), 16'h0010, 1'b0);
    wr(A(0), 16'h0004, 1'b0);
    op(1'b0, 1'b0, '0, '0, 1'b1, '0, 1'b0);
    chk("irq_before_rst", 32'(irq), 32'd1);
    wr(A(3), 16'h0333, 1'b0);
    wr(A(0), 16'h0005, 1'b0);
    chk("start_before_rst", 32'(start_pulse), 32'd1);
    chk("active3_before_rst", 32'(act_sl(3)), 32'h00000333);
    rst = 1'b1;
    #1;
    chk("rst_start_low", 32'(start_pulse), 32'd0);
    chk("rst_irq_low", 32'(irq), 32'd0);
    chk("rst_rd_valid", 32'(bus_if.rd_valid), 32'd0);
    chk("rst_read_data", 32'(bus_if.read_data), 32'd0);
    chk("rst_acc_err", 32'(bus_if.acc_err), 32'd0);
    exp_bank = '0;
    for (int i = 1; i < int'(NR); i++) begin
      if (!RO_M[i]) exp_bank[i*DW +: DW] = 16'hA000 + 16'(i);
    end
    n_chk++;
    if (cfg_active === exp_bank) n_pass++;
    else $display("FAIL rst_cfg_active: got 'h%0h expected 'h%0h", cfg_active, exp_bank);
    @(negedge clk);
    rst = 1'b0;
    rd(A(3), 16'hA003, 1'b0);
    rd(A(1), 16'hA001, 1'b0);
    rd(A(0), 16'h0000, 1'b0);
    chk("post_rst_active1", 32'(act_sl(1)), 32'h0000A001);

    repeat (3) @(negedge clk);
    chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    chk("err_queue_drained", 32'(err_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
